// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the TinyChip instruction fetch front end.
//   PC_W          program counter / instruction address width
//   INSTR_W       instruction width
//   fetch_state_t fetch FSM states
//   fetch_entry_t one prefetch FIFO entry: instruction plus the address it came from
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO holding fetched instructions with their addresses.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   push, wdata enqueue wdata (caller guarantees room, or a pop in the same cycle)
//   pop         dequeue the head (ignored when empty)
//   flush       discard every entry; wins over push and over pop's pointer update
//   head        oldest entry (contents undefined when empty)
//   count       number of valid entries
//   empty, full occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop && !empty;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by count_q,
    // so clearing the data would only cost reset routing.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end for the 9-bit TinyChip core.
// Owns the PC, issues reads to a one-cycle-latency synchronous instruction memory,
// buffers returns in fetch_fifo and hands them to the controller on valid/ready.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   imem_rd_en, imem_addr      read request and address (this cycle)
//   imem_rdata                 read data, valid the cycle after the request
//   instr_valid/data/pc        FIFO head towards the controller
//   instr_ready                controller consumes the head this cycle
//   redirect_valid/target      control-flow change from the controller
//   halt                       stop fetching (level); HALTED is left only by reset
//   done                       halted, FIFO drained and no read outstanding
// PC_W and INSTR_W come from fetch_pkg; DEPTH is the FIFO size (power of two, >= 2).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               halt,
    output logic               done
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OCC_W = CW + 1;

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [PC_W-1:0] rd_pc_q, rd_pc_d;   // address of the read in flight
    logic            epoch_q, epoch_d;
    logic            inflight_q, inflight_d;
    logic            tag_q,   tag_d;     // epoch the in-flight read was issued in

    logic             issue;
    logic             credit_ok;
    logic             ret_accept;
    logic [OCC_W-1:0] occupancy;

    fetch_entry_t  fifo_wdata;
    fetch_entry_t  fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    // ---------------------------------------------------------------- FIFO
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign instr_valid = !reset && !fifo_empty;
    assign instr_data  = instr_valid ? fifo_head.instr : '0;
    assign instr_pc    = instr_valid ? fifo_head.pc    : '0;
    assign fifo_pop    = instr_valid && instr_ready;

    // A redirect flushes the FIFO after this cycle's pop; the FIFO gives flush priority,
    // which also drops a read returning in the redirect cycle.
    assign fifo_flush  = redirect_valid;

    // Returns tagged with a stale epoch belong to a squashed fetch stream.
    assign ret_accept  = inflight_q && (tag_q == epoch_q);
    // The credit rule keeps ret_accept off a full, non-popping FIFO; the guard only
    // stops a stray push from overwriting the head.
    assign fifo_push   = ret_accept && (!fifo_full || fifo_pop);
    assign fifo_wdata  = '{pc: rd_pc_q, instr: imem_rdata};

    // ---------------------------------------------------------------- issue / credit
    // Buffered entries plus the outstanding read, minus the entry leaving this cycle,
    // must leave room for one more return.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(fifo_pop);
    assign credit_ok = (occupancy < OCC_W'(DEPTH));

    assign issue = !reset && (state_q == RUN) && !redirect_valid && !halt && credit_ok;

    assign imem_rd_en = issue;
    assign imem_addr  = pc_q;

    assign done = !reset && (state_q == HALTED) && fifo_empty && !inflight_q;

    // ---------------------------------------------------------------- next state
    // NOTE: every always_comb output gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        epoch_d    = epoch_q;
        tag_d      = tag_q;
        inflight_d = issue;
        if (issue) begin
            pc_d    = pc_q + PC_W'(1);
            rd_pc_d = pc_q;
            tag_d   = epoch_q;
        end
        if (redirect_valid) begin
            pc_d    = redirect_target;
            epoch_d = ~epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= '0;
            rd_pc_q    <= '0;
            epoch_q    <= 1'b0;
            tag_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            epoch_q    <= epoch_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            if ((state_q == RUN) && halt) begin
                state_q <= HALTED;
            end
        end
    end

endmodule
